// File: rtl/dimred_pkg.sv
// -----------------------------------------------------------------------------
// dimred_pkg
// Shared types and constants for the PDSCH dimension-reduction sequencing
// controller: FSM state encoding, RBG length lookup and error bit positions.
// -----------------------------------------------------------------------------
package dimred_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BURST   = 2'd2,
        SYM_END = 2'd3
    } state_t;

    localparam logic [15:0] RBG_LEN_48  = 16'd48;
    localparam logic [15:0] RBG_LEN_96  = 16'd96;
    localparam logic [15:0] RBG_LEN_192 = 16'd192;

    // o_err bit positions
    localparam int ERR_PARTIAL  = 0;   // burst ended mid-RBG
    localparam int ERR_IDLE_VLD = 1;   // tvalid seen while IDLE

    // RBG size code to RE count; the spare code 11 maps to 48
    function automatic logic [15:0] rbg_len_lut(input logic [1:0] sel);
        logic [15:0] len;
        case (sel)
            2'b01:   len = RBG_LEN_96;
            2'b10:   len = RBG_LEN_192;
            default: len = RBG_LEN_48;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rbg_strobe_gen.sv
// -----------------------------------------------------------------------------
// rbg_strobe_gen
// Tracks the RE position inside the current RBG and the RBG index inside the
// current burst, and decodes the accumulator load/slip strobes plus the
// post-burst flush pulse.
//
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_clear           slot (re)start: clears the counters
//   i_re_vld          RE valid, aligned with the MAC sum cycle
//   i_fall            last RE of a burst in an active slot
//   i_rbg_len         latched RBG length in REs
//   o_rbg_load        first RE of an RBG
//   o_rbg_slip        last RE of an RBG
//   o_rbg_flush       one cycle after the last RE of a burst
//   o_rbg_num         RBG index within the burst
//   o_partial         burst is ending on an RE that is not the last of an RBG
// -----------------------------------------------------------------------------
module rbg_strobe_gen
    import dimred_pkg::*;
#(
    parameter int RE_W  = 16,
    parameter int RBG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_re_vld,
    input  logic             i_fall,
    input  logic [RE_W-1:0]  i_rbg_len,
    output logic             o_rbg_load,
    output logic             o_rbg_slip,
    output logic             o_rbg_flush,
    output logic [RBG_W-1:0] o_rbg_num,
    output logic             o_partial
);

    logic [RE_W-1:0]  re_num_q;
    logic [RBG_W-1:0] rbg_num_q;
    logic             flush_q;
    logic             last_s;

    assign last_s      = (re_num_q == (i_rbg_len - RE_W'(1'b1)));
    assign o_rbg_load  = i_re_vld & (re_num_q == '0);
    assign o_rbg_slip  = i_re_vld & last_s;
    assign o_rbg_flush = flush_q;
    assign o_rbg_num   = rbg_num_q;
    assign o_partial   = i_fall & ~last_s;

    // RE position in the RBG, RBG index in the burst, and the flush pulse
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            re_num_q  <= '0;
            rbg_num_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            // the flush follows every burst end, even one cut by a restart,
            // so the sum stage never holds a half-captured accumulator
            flush_q <= i_fall;

            if (i_clear || i_fall) begin
                re_num_q <= '0;
            end else if (i_re_vld) begin
                re_num_q <= last_s ? '0 : re_num_q + RE_W'(1'b1);
            end

            if (i_clear || !i_re_vld) begin
                rbg_num_q <= '0;
            end else if (o_rbg_slip) begin
                rbg_num_q <= rbg_num_q + RBG_W'(1'b1);
            end
        end
    end

endmodule

// File: rtl/dimred_sym_ctrl.sv
// -----------------------------------------------------------------------------
// dimred_sym_ctrl
// Sequencing controller for the PDSCH dimension-reduction path. Counts beam
// blocks (tvalid bursts) per symbol and symbols per slot, and drives the RBG
// accumulator strobes and symbol/slot completion flags.
//
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_slot_start      arms or restarts a slot; latches i_rbg_size
//   i_rbg_size        RBG size code (00/11=48, 01=96, 10=192 REs)
//   i_beams_tvalid    beam-MAC output valid
//   o_re_vld          tvalid delayed one cycle, gated by an active slot
//   o_rbg_load/slip   first/last RE of an RBG
//   o_rbg_flush       one cycle after a burst ends
//   o_rbg_num         RBG index within the burst
//   o_blk_idx         block index within the symbol
//   o_sym_idx         symbol index within the slot
//   o_sym_pulse       symbol end pulse
//   o_sym1_done       sticky: first symbol of the slot complete
//   o_slot_done       slot end pulse
//   o_err             sticky errors: bit0 partial RBG, bit1 tvalid while IDLE
//   o_busy            FSM not IDLE
// -----------------------------------------------------------------------------
module dimred_sym_ctrl
    import dimred_pkg::*;
#(
    parameter int BLK_PER_SYM  = 4,
    parameter int SYM_PER_SLOT = 14,
    parameter int RE_W         = 16,
    parameter int RBG_W        = 8,
    parameter int BLK_W        = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_slot_start,
    input  logic [1:0]       i_rbg_size,
    input  logic             i_beams_tvalid,
    output logic             o_re_vld,
    output logic             o_rbg_load,
    output logic             o_rbg_slip,
    output logic             o_rbg_flush,
    output logic [RBG_W-1:0] o_rbg_num,
    output logic [BLK_W-1:0] o_blk_idx,
    output logic [3:0]       o_sym_idx,
    output logic             o_sym_pulse,
    output logic             o_sym1_done,
    output logic             o_slot_done,
    output logic [1:0]       o_err,
    output logic             o_busy
);

    state_t           state_q;
    logic             v1_q;
    logic [RE_W-1:0]  rbg_len_q;
    logic [BLK_W-1:0] blk_idx_q;
    logic [3:0]       sym_idx_q;
    logic             sym_pulse_q;
    logic             sym1_done_q;
    logic             slot_done_q;
    logic [1:0]       err_q;

    logic             re_vld_s;
    logic             fall_s;
    logic             partial_s;

    // Gating by state keeps bursts that arrive outside a slot from producing
    // any strobes or being mistaken for a partial RBG.
    assign re_vld_s = v1_q & (state_q != IDLE);
    assign fall_s   = re_vld_s & ~i_beams_tvalid;

    assign o_re_vld    = re_vld_s;
    assign o_blk_idx   = blk_idx_q;
    assign o_sym_idx   = sym_idx_q;
    assign o_sym_pulse = sym_pulse_q;
    assign o_sym1_done = sym1_done_q;
    assign o_slot_done = slot_done_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != IDLE);

    // One-cycle delay of the MAC valid, aligning REs with the MAC sum cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= i_beams_tvalid;
        end
    end

    // Slot sequencer: block/symbol counting, completion flags and errors
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            rbg_len_q   <= RE_W'(RBG_LEN_48);
            blk_idx_q   <= '0;
            sym_idx_q   <= 4'd0;
            sym_pulse_q <= 1'b0;
            sym1_done_q <= 1'b0;
            slot_done_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            sym_pulse_q <= 1'b0;
            slot_done_q <= 1'b0;

            if (i_slot_start) begin
                // a (re)start wins over a coincident burst end: no block counted
                state_q     <= WAIT;
                rbg_len_q   <= RE_W'(rbg_len_lut(i_rbg_size));
                blk_idx_q   <= '0;
                sym_idx_q   <= 4'd0;
                sym1_done_q <= 1'b0;
                err_q       <= 2'b00;
            end else begin
                if (partial_s) begin
                    err_q[ERR_PARTIAL] <= 1'b1;
                end
                if ((state_q == IDLE) && i_beams_tvalid) begin
                    err_q[ERR_IDLE_VLD] <= 1'b1;
                end

                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    WAIT: begin
                        if (i_beams_tvalid) begin
                            state_q <= BURST;
                        end
                    end
                    BURST: begin
                        if (fall_s) begin
                            if (blk_idx_q == BLK_W'(BLK_PER_SYM - 1)) begin
                                // last block: the index is held and cleared in
                                // SYM_END so it never shows BLK_PER_SYM
                                state_q     <= SYM_END;
                                sym_pulse_q <= 1'b1;
                                slot_done_q <= (sym_idx_q == 4'(SYM_PER_SLOT - 1));
                                if (sym_idx_q == 4'd0) begin
                                    sym1_done_q <= 1'b1;
                                end
                            end else begin
                                blk_idx_q <= blk_idx_q + BLK_W'(1'b1);
                                state_q   <= WAIT;
                            end
                        end
                    end
                    SYM_END: begin
                        blk_idx_q <= '0;
                        if (sym_idx_q == 4'(SYM_PER_SLOT - 1)) begin
                            sym_idx_q <= 4'd0;
                            state_q   <= IDLE;
                        end else begin
                            sym_idx_q <= sym_idx_q + 4'd1;
                            state_q   <= WAIT;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    rbg_strobe_gen #(
        .RE_W  (RE_W),
        .RBG_W (RBG_W)
    ) u_strobe (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (i_slot_start),
        .i_re_vld    (re_vld_s),
        .i_fall      (fall_s),
        .i_rbg_len   (rbg_len_q),
        .o_rbg_load  (o_rbg_load),
        .o_rbg_slip  (o_rbg_slip),
        .o_rbg_flush (o_rbg_flush),
        .o_rbg_num   (o_rbg_num),
        .o_partial   (partial_s)
    );

endmodule

// File: tb/tb_dimred_sym_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dimred_sym_ctrl
// Self-checking bench for dimred_sym_ctrl.
// -----------------------------------------------------------------------------
module tb_dimred_sym_ctrl;

    logic       clk;
    logic       rst_n;
    logic       slot_start;
    logic [1:0] rbg_size;
    logic       tvalid;
    logic       re_vld, rbg_load, rbg_slip, rbg_flush;
    logic [7:0] rbg_num, blk_idx;
    logic [3:0] sym_idx;
    logic       sym_pulse, sym1_done, slot_done, busy;
    logic [1:0] err;

    dimred_sym_ctrl dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_slot_start   (slot_start),
        .i_rbg_size     (rbg_size),
        .i_beams_tvalid (tvalid),
        .o_re_vld       (re_vld),
        .o_rbg_load     (rbg_load),
        .o_rbg_slip     (rbg_slip),
        .o_rbg_flush    (rbg_flush),
        .o_rbg_num      (rbg_num),
        .o_blk_idx      (blk_idx),
        .o_sym_idx      (sym_idx),
        .o_sym_pulse    (sym_pulse),
        .o_sym1_done    (sym1_done),
        .o_slot_done    (slot_done),
        .o_err          (err),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       slip;
        logic [7:0] num;
    } sb_t;

    typedef struct {
        logic [1:0] size;    // latched at slot start
        logic [1:0] mid;     // driven after slot start (must be ignored)
        int         len;     // burst length in REs
        int         n;       // RBG length implied by size
        int         loads;   // expected load strobes
        int         slips;   // expected slip strobes
        logic [1:0] err;     // expected o_err after the burst
    } vec_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vt[8];

    int n_vec = 0;
    int n_err = 0;
    int cnt_load, cnt_slip, cnt_flush, cnt_sym, cnt_slot;
    int exp_blk, exp_sym;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_load = 0; cnt_slip = 0; cnt_flush = 0; cnt_sym = 0; cnt_slot = 0;
    endtask

    task automatic start_slot(input logic [1:0] sz);
        rbg_size   = sz;
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        exp_blk    = 0;
        exp_sym    = 0;
    endtask

    // drive len REs with RBG length n, queue the per-RE expectation, then a gap
    task automatic burst(input int len, input int n);
        for (int k = 0; k < len; k++) begin
            tvalid = 1'b1;
            sb.push_back('{(k % n) == 0, (k % n) == (n - 1), 8'(k / n)});
            tick();
        end
        tvalid = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({re_vld, rbg_load, rbg_slip, rbg_flush, rbg_num, blk_idx,
                    sym_idx, sym_pulse, sym1_done, slot_done, err, busy});
    endfunction

    // per-RE scoreboard and strobe counters
    always @(negedge clk) begin
        if (mon_en) begin
            if (re_vld) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("rbg_load", 32'(rbg_load), 32'(mon_e.load));
                    chk("rbg_slip", 32'(rbg_slip), 32'(mon_e.slip));
                    chk("rbg_num",  32'(rbg_num),  32'(mon_e.num));
                    chk("blk_idx",  32'(blk_idx),  32'(exp_blk));
                    chk("sym_idx",  32'(sym_idx),  32'(exp_sym));
                end
            end else begin
                chk("strobe_without_vld", 32'({rbg_load, rbg_slip}), 32'd0);
            end
            cnt_load  += int'(rbg_load);
            cnt_slip  += int'(rbg_slip);
            cnt_flush += int'(rbg_flush);
            cnt_sym   += int'(sym_pulse);
            cnt_slot  += int'(slot_done);
        end
    end

    initial begin
        vt[0] = '{2'b00, 2'b00,  96,  48, 2, 2, 2'b00};
        vt[1] = '{2'b00, 2'b00,  50,  48, 2, 1, 2'b01};
        vt[2] = '{2'b01, 2'b01,  96,  96, 1, 1, 2'b00};
        vt[3] = '{2'b10, 2'b10,   1, 192, 1, 0, 2'b01};
        vt[4] = '{2'b11, 2'b11,  48,  48, 1, 1, 2'b00};
        vt[5] = '{2'b10, 2'b10, 200, 192, 2, 1, 2'b01};
        vt[6] = '{2'b00, 2'b10,  96,  48, 2, 2, 2'b00};
        vt[7] = '{2'b01, 2'b00,  97,  96, 2, 1, 2'b01};

        rst_n = 1'b0; slot_start = 1'b0; rbg_size = 2'b00; tvalid = 1'b0;
        exp_blk = 0; exp_sym = 0;
        clr_cnt();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_outputs", all_outs(), 32'd0);
        mon_en = 1'b1;

        // 96-RE burst at 48 REs/RBG with exact flush timing
        start_slot(2'b00);
        chk("busy_after_start", 32'(busy), 32'd1);
        clr_cnt();
        for (int k = 0; k < 96; k++) begin
            tvalid = 1'b1;
            sb.push_back('{(k % 48) == 0, (k % 48) == 47, 8'(k / 48)});
            tick();
        end
        tvalid = 1'b0;
        chk("last_re_vld", 32'(re_vld), 32'd1);
        chk("flush_early", 32'(rbg_flush), 32'd0);
        tick();
        chk("flush_pulse", 32'(rbg_flush), 32'd1);
        chk("re_vld_off", 32'(re_vld), 32'd0);
        tick();
        chk("flush_once", 32'(rbg_flush), 32'd0);
        tick();
        chk("t1_loads", 32'(cnt_load), 32'd2);
        chk("t1_slips", 32'(cnt_slip), 32'd2);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_blk_after", 32'(blk_idx), 32'd1);

        // table of single-burst slots
        for (int i = 0; i < 8; i++) begin
            start_slot(vt[i].size);
            rbg_size = vt[i].mid;
            clr_cnt();
            burst(vt[i].len, vt[i].n);
            chk("tbl_loads", 32'(cnt_load), 32'(vt[i].loads));
            chk("tbl_slips", 32'(cnt_slip), 32'(vt[i].slips));
            chk("tbl_flush", 32'(cnt_flush), 32'd1);
            chk("tbl_err", 32'(err), 32'(vt[i].err));
            chk("tbl_sb_drained", 32'(sb.size()), 32'd0);
        end

        // partial-RBG error is sticky until the next slot start
        start_slot(2'b00);
        burst(50, 48);
        exp_blk = 1;
        burst(48, 48);
        chk("err0_sticky", 32'(err), 32'd1);
        start_slot(2'b00);
        chk("err0_cleared", 32'(err), 32'd0);

        // restart coinciding with the end of the third burst of symbol 0
        start_slot(2'b01);
        clr_cnt();
        burst(96, 96);
        exp_blk = 1;
        burst(96, 96);
        exp_blk = 2;
        for (int k = 0; k < 96; k++) begin
            tvalid = 1'b1;
            sb.push_back('{(k % 96) == 0, (k % 96) == 95, 8'(k / 96)});
            tick();
        end
        tvalid     = 1'b0;
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        repeat (2) tick();
        chk("restart_blk", 32'(blk_idx), 32'd0);
        chk("restart_sym1", 32'(sym1_done), 32'd0);
        chk("restart_sym_pulse", 32'(cnt_sym), 32'd0);
        for (int b = 0; b < 4; b++) begin
            exp_blk = b;
            exp_sym = 0;
            burst(96, 96);
        end
        chk("restart_sym_pulse_after", 32'(cnt_sym), 32'd1);
        chk("restart_sym1_after", 32'(sym1_done), 32'd1);
        chk("restart_sym_idx", 32'(sym_idx), 32'd1);

        // full slot: 14 symbols x 4 blocks of 192 REs
        start_slot(2'b10);
        clr_cnt();
        for (int s = 0; s < 14; s++) begin
            for (int b = 0; b < 4; b++) begin
                exp_sym = s;
                exp_blk = b;
                burst(192, 192);
            end
            if (s == 0) begin
                chk("sym1_done_rise", 32'(sym1_done), 32'd1);
                chk("sym_pulse_first", 32'(cnt_sym), 32'd1);
            end
        end
        chk("slot_done_once", 32'(cnt_slot), 32'd1);
        chk("sym_pulses", 32'(cnt_sym), 32'd14);
        chk("slot_loads", 32'(cnt_load), 32'd56);
        chk("slot_sym_idx", 32'(sym_idx), 32'd0);
        chk("slot_busy", 32'(busy), 32'd0);
        chk("slot_sym1_hold", 32'(sym1_done), 32'd1);
        chk("slot_err", 32'(err), 32'd0);
        clr_cnt();
        tvalid = 1'b1;
        repeat (4) tick();
        tvalid = 1'b0;
        repeat (3) tick();
        chk("idle_tvalid_err", 32'(err), 32'd2);
        chk("idle_no_load", 32'(cnt_load), 32'd0);
        chk("idle_no_flush", 32'(cnt_flush), 32'd0);

        // synchronous reset in the middle of a burst
        start_slot(2'b00);
        chk("err1_cleared", 32'(err), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tvalid = 1'b1;
            sb.push_back('{(k % 48) == 0, (k % 48) == 47, 8'(k / 48)});
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midburst_reset_outputs", all_outs(), 32'd0);
        clr_cnt();
        repeat (4) tick();
        tvalid = 1'b0;
        repeat (3) tick();
        chk("post_reset_err", 32'(err), 32'd2);
        chk("post_reset_flush", 32'(cnt_flush), 32'd0);
        chk("post_reset_load", 32'(cnt_load), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("final_sb_drained", 32'(sb.size()), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dimred_sym_ctrl.md
Name: dimred_sym_ctrl

Overview:
Sequencing controller for the PDSCH dimension-reduction path. Watches the beam-MAC output valid and counts RE bursts (beam blocks) and symbols within a slot. Drives the RBG accumulator load/slip/flush strobes and the symbol-done flags that the CPRI unpackers and RBG summing stage consume. Sits between the mac_beams output and the rbG accumulate/sum logic, and replaces the ad-hoc counters around them.

Parameters:
BLK_PER_SYM, 4, beam blocks (tvalid bursts) per symbol
SYM_PER_SLOT, 14, symbols per slot
RE_W, 16, RE counter width
RBG_W, 8, RBG index width
BLK_W, 8, block index width

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  reset; synchronous, active-low
i_slot_start  in  1  one-cycle pulse that arms or restarts a slot
i_rbg_size  in  2  00=48, 01=96, 10=192, 11=48 REs per RBG; latched on i_slot_start
i_beams_tvalid  in  1  MAC output valid; high for each RE of a block burst
o_re_vld  out  1  i_beams_tvalid delayed 1 cycle, gated by an active slot
o_rbg_load  out  1  first RE of an RBG; accumulator loads instead of adding
o_rbg_slip  out  1  last RE of an RBG
o_rbg_flush  out  1  one-cycle pulse after a burst ends; sum register captures accumulator
o_rbg_num  out  RBG_W  RBG index within the current burst
o_blk_idx  out  BLK_W  block index within the current symbol
o_sym_idx  out  4  symbol index within the slot
o_sym_pulse  out  1  one-cycle pulse at symbol end
o_sym1_done  out  1  sticky: first symbol of the slot complete (feeds unpack i_sym1_done)
o_slot_done  out  1  one-cycle pulse at slot end
o_err  out  2  sticky; bit0 = burst ended mid-RBG, bit1 = tvalid seen while IDLE
o_busy  out  1  FSM is not in IDLE

Behaviour:
- Reset (i_reset_n=0 at a clock edge): FSM goes to IDLE. Every output and counter becomes 0, and the latched RBG length becomes 48. Reset mid-burst aborts the burst silently.
- v1 = i_beams_tvalid registered. fall = v1 & ~i_beams_tvalid.
- FSM states:
  - IDLE: go to WAIT on i_slot_start.
  - WAIT: go to BURST when i_beams_tvalid=1.
  - BURST: on fall, go to WAIT, or to SYM_END if blk_idx==BLK_PER_SYM-1.
  - SYM_END (1 cycle): o_sym_pulse=1 and blk_idx clears.
    - If sym_idx==SYM_PER_SLOT-1: o_slot_done=1, sym_idx clears, go to IDLE.
    - Otherwise: sym_idx increments, go to WAIT.
- o_re_vld = v1 when the FSM is not IDLE, else 0.
- re_num increments on each o_re_vld.
  - It wraps to 0 after reaching N-1, where N is the latched RBG length.
  - It clears to 0 one cycle after fall.
- o_rbg_load = o_re_vld & (re_num==0). o_rbg_slip = o_re_vld & (re_num==N-1). Both are combinational decodes of registers, aligned with the MAC sum cycle.
- o_rbg_num: increments on o_rbg_slip; clears when o_re_vld=0.
- o_rbg_flush: registered fall, so it fires 1 cycle after the last o_re_vld.
- Block count: blk_idx increments on fall in BURST.
- o_sym1_done:
  - Set at the SYM_END where sym_idx==0.
  - Cleared by i_slot_start or reset only.
- o_err[0]: set if fall occurs while re_num!=N-1 (partial RBG). The flush still fires.
- o_err[1]: set if i_beams_tvalid=1 while the FSM is IDLE. No strobes are produced.
- o_err is cleared by i_slot_start.
- i_slot_start while not IDLE:
  - Restarts the slot: counters clear, o_sym1_done clears, o_err clears, FSM goes to WAIT, rbg_size is re-latched.
  - If it coincides with fall, the restart wins and no block is counted.
- A burst of length 1 is legal: load, slip (if N==1 is impossible, only load), and flush all occur.
- i_rbg_size changes mid-slot have no effect until the next i_slot_start.

Decomposition:
- Package dimred_pkg holds:
  - typedef state_t {IDLE, WAIT, BURST, SYM_END};
  - RBG_LEN_LUT constants 48/96/192;
  - the err bit indices.
- One sub-module, rbg_strobe_gen, is natural: the re_num/rbg_num counters plus the load/slip/flush decode. It is instantiated once.

Test Plan:
1. Reset, then i_slot_start with rbg_size=00, then one 96-cycle tvalid burst -> o_rbg_load 2x (RE 0, 48); o_rbg_slip 2x (RE 47, 95); o_rbg_num goes 0 then 1; o_rbg_flush 1 cycle after the last o_re_vld; o_err=0.
2. BLK_PER_SYM=4: four bursts of 192 REs with size=10 -> o_blk_idx 0..3; o_sym_pulse once after the 4th burst; o_sym1_done rises then and stays high.
3. 14 symbols × 4 blocks -> o_slot_done pulse once; o_sym_idx back to 0; o_busy=0; further tvalid sets o_err[1] with no strobes.
4. Burst of 50 REs with size=00 -> slip at RE 47; load at RE 48; flush fires; o_err[0]=1 until the next i_slot_start.
5. i_slot_start during the 3rd burst of symbol 0 -> counters clear; o_sym1_done stays 0; the next 4 bursts produce o_sym_pulse.
6. i_reset_n=0 held for 1 cycle mid-burst -> all outputs 0 next cycle; FSM IDLE; remaining tvalid sets o_err[1] only.
